// File: rtl/systolic_result_drain_if.sv
// Result stream port of the systolic drain: one DW-bit word per valid/ready handshake.
interface systolic_result_drain_if #(
  parameter int DW = 16,
  parameter int IW = 4
);
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [IW-1:0] res_idx;
  logic          res_last;

  modport master (output res_valid, res_data, res_idx, res_last, input res_ready);
  modport slave  (input res_valid, res_data, res_idx, res_last, output res_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Waits a fixed fill latency after start, snapshots the array's C bus, then
// streams the N*N results out in row-major order over a valid/ready port.
module systolic_result_drain #(
  parameter int N       = 3,
  parameter int DW      = 16,
  parameter int LATENCY = 8,
  parameter int IW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*DW-1:0]   c_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  systolic_result_drain_if.master res
);
  localparam int NW = N * N;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt;
  logic [IW-1:0]     idx;
  logic [NW*DW-1:0]  snap;
  logic              xfer;
  logic              last_word;

  assign xfer      = (state == STREAM) && res.res_ready;
  assign last_word = (idx == IW'(NW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = STREAM;
      STREAM:  if (xfer && last_word) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= xfer && last_word;
      // A start that arrives while a job is in flight is dropped, but remembered.
      if (start && state != IDLE) err <= 1'b1;
      case (state)
        IDLE:   if (start) cnt <= 8'(LATENCY - 1);
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            snap <= c_in;
            idx  <= '0;
          end
        end
        STREAM: if (xfer && !last_word) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registers only, so reset clears them immediately.
  always_comb begin
    busy          = (state != IDLE);
    res.res_valid = (state == STREAM);
    res.res_data  = '0;
    res.res_idx   = '0;
    res.res_last  = 1'b0;
    if (state == STREAM) begin
      res.res_idx  = idx;
      res.res_last = last_word;
      for (int unsigned i = 0; i < NW; i++) begin
        if (idx == IW'(i)) res.res_data = snap[i*DW +: DW];
      end
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: table of jobs plus a LATENCY=1 sequence.
module tb_systolic_result_drain;
  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [143:0] c_in = '0;
  logic         busy, done, err;
  logic         start1 = 1'b0;
  logic [143:0] c_in1 = '0;
  logic         busy1, done1, err1;

  systolic_result_drain_if #(.DW(16), .IW(4)) rif ();
  systolic_result_drain_if #(.DW(16), .IW(4)) rif1 ();

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in),
    .busy(busy), .done(done), .err(err), .res(rif)
  );

  systolic_result_drain #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .c_in(c_in1),
    .busy(busy1), .done(done1), .err(err1), .res(rif1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] rand144();
    logic [143:0] r;
    for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  typedef struct {
    logic [143:0] c;          // array results present at the snapshot edge
    int           ready_mode; // 0 always ready, 1 pattern 1,0,0, 2 random
    bit           iso;        // drive all-ones after the snapshot
    bit           poke_wait;  // extra start during WAIT
    bit           poke_last;  // extra start on the final transfer
    int           abort_at;   // reset after this many transfers (9 = none)
    bit           exp_err;    // expected err at the end of the job
  } job_t;

  task automatic run_job(input job_t j);
    logic [15:0] q[$];
    int n, cyc;
    bit rdy, saw_done;
    start = 1'b1;
    c_in  = rand144();
    res_ready_set(1'b0);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_wait", rif.res_valid, 0);
    for (int t = 1; t <= LAT; t++) begin
      c_in  = (t == LAT) ? j.c : rand144();
      start = (j.poke_wait && t == 3);
      step();
      start = 1'b0;
      if (t < LAT) begin
        if (rif.res_valid !== 1'b0 || busy !== 1'b1) chk("wait_state", {rif.res_valid, busy}, 2'b01);
      end else begin
        chk("valid_after_latency", rif.res_valid, 1);
      end
    end
    // Reference: the words to be streamed are whatever c_in held at the snapshot edge.
    for (int i = 0; i < 9; i++) q.push_back(j.c[i*16 +: 16]);
    c_in = j.iso ? '1 : rand144();
    n = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (n == j.abort_at) break;
      case (j.ready_mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      res_ready_set(rdy);
      start = j.poke_last && rdy && (q.size() == 1);
      chk("valid", rif.res_valid, 1);
      chk("data", rif.res_data, q[0]);
      chk("idx", rif.res_idx, n);
      chk("last", rif.res_last, q.size() == 1);
      chk("done_low_in_stream", done, 0);
      step();
      start = 1'b0;
      if (rdy) begin
        void'(q.pop_front());
        n++;
      end
      cyc++;
      c_in = j.iso ? '1 : rand144();
    end
    res_ready_set(1'b0);
    if (j.abort_at < 9) begin
      #3 rst = 1'b1;
      #1;
      chk("rst_valid", rif.res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", rif.res_data, 0);
      chk("rst_idx", rif.res_idx, 0);
      chk("rst_err", err, 0);
      #2 rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (done) saw_done = 1'b1;
      end
      chk("no_done_after_abort", saw_done, 0);
      return;
    end
    chk("transfers", n, 9);
    chk("done_pulse", done, 1);
    chk("busy_after_job", busy, 0);
    chk("valid_after_job", rif.res_valid, 0);
    step();
    chk("done_once", done, 0);
    chk("err", err, j.exp_err);
  endtask

  task automatic res_ready_set(input bit v);
    rif.res_ready = v;
  endtask

  logic [15:0]  nom [9] = '{16'd30, 16'd36, 16'd42, 16'd66, 16'd81, 16'd96, 16'd102, 16'd126, 16'd150};
  logic [143:0] nom_c;
  job_t         jobs [12];

  initial begin
    rif.res_ready  = 1'b0;
    rif1.res_ready = 1'b0;
    for (int i = 0; i < 9; i++) nom_c[i*16 +: 16] = nom[i];

    jobs[0]  = '{nom_c,     0, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    jobs[1]  = '{nom_c,     1, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    jobs[2]  = '{nom_c,     0, 1'b1, 1'b0, 1'b0, 9, 1'b0};
    jobs[3]  = '{nom_c,     0, 1'b0, 1'b1, 1'b1, 9, 1'b1};
    jobs[4]  = '{nom_c,     1, 1'b0, 1'b0, 1'b0, 9, 1'b1};
    jobs[5]  = '{rand144(), 2, 1'b0, 1'b0, 1'b0, 9, 1'b1};
    jobs[6]  = '{nom_c,     0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
    jobs[7]  = '{nom_c,     0, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    for (int i = 8; i < 12; i++) jobs[i] = '{rand144(), 2, 1'b0, 1'b0, 1'b0, 9, 1'b0};

    #3;
    chk("reset_busy", busy, 0);
    chk("reset_valid", rif.res_valid, 0);
    chk("reset_data", rif.res_data, 0);
    chk("reset_idx", rif.res_idx, 0);
    chk("reset_last", rif.res_last, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    #9 rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_job(jobs[i]);

    // LATENCY=1 instance: snapshot one edge after start.
    c_in1  = rand144();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("l1_busy", busy1, 1);
    chk("l1_valid_wait", rif1.res_valid, 0);
    c_in1 = nom_c;
    step();
    c_in1 = '1;
    chk("l1_valid", rif1.res_valid, 1);
    rif1.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("l1_data", rif1.res_data, nom[i]);
      chk("l1_idx", rif1.res_idx, i);
      step();
    end
    rif1.res_ready = 1'b0;
    chk("l1_done", done1, 1);
    chk("l1_err", err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
